// File: rtl/fnd_pkg.sv
// Shared constants and types for the 4-digit 7-segment (FND) display path.
// Segment patterns are active-low, bit order {dp,g,f,e,d,c,b,a}; dp is always off.
package fnd_pkg;

  localparam int DIGIT_W = 4;
  localparam int SEG_W   = 8;
  localparam int SEL_W   = 2;
  localparam int NIBBLE_W = 4;

  typedef logic [DIGIT_W-1:0] digit_t;
  typedef logic [SEG_W-1:0]   seg_t;

  localparam seg_t SEG_0 = 8'hC0;
  localparam seg_t SEG_1 = 8'hF9;
  localparam seg_t SEG_2 = 8'hA4;
  localparam seg_t SEG_3 = 8'hB0;
  localparam seg_t SEG_4 = 8'h99;
  localparam seg_t SEG_5 = 8'h92;
  localparam seg_t SEG_6 = 8'h82;
  localparam seg_t SEG_7 = 8'hF8;
  localparam seg_t SEG_8 = 8'h80;
  localparam seg_t SEG_9 = 8'h90;
  localparam seg_t SEG_A = 8'h88;
  localparam seg_t SEG_B = 8'h83;
  localparam seg_t SEG_C = 8'hC6;
  localparam seg_t SEG_D = 8'hA1;
  localparam seg_t SEG_E = 8'h86;
  localparam seg_t SEG_F = 8'h8E;

  localparam seg_t   SEG_BLANK = 8'hFF;
  localparam digit_t DIGIT_OFF = 4'hF;

  // Active-low one-hot anode enable; an unknown index falls through to all-off.
  function automatic digit_t digit_decode(input logic [SEL_W-1:0] sel);
    digit_t d;
    d = DIGIT_OFF;
    case (sel)
      2'd0:    d = 4'b1110;
      2'd1:    d = 4'b1101;
      2'd2:    d = 4'b1011;
      2'd3:    d = 4'b0111;
      default: d = DIGIT_OFF;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/fnd_font_rom.sv
// Combinational hex-nibble to active-low 7-segment font lookup.
// An unknown nibble maps to a blank pattern so the display never shows X.
module fnd_font_rom
  import fnd_pkg::*;
(
  input  logic [NIBBLE_W-1:0] value,
  output seg_t                font
);

  always_comb begin
    font = SEG_BLANK;
    case (value)
      4'h0:    font = SEG_0;
      4'h1:    font = SEG_1;
      4'h2:    font = SEG_2;
      4'h3:    font = SEG_3;
      4'h4:    font = SEG_4;
      4'h5:    font = SEG_5;
      4'h6:    font = SEG_6;
      4'h7:    font = SEG_7;
      4'h8:    font = SEG_8;
      4'h9:    font = SEG_9;
      4'hA:    font = SEG_A;
      4'hB:    font = SEG_B;
      4'hC:    font = SEG_C;
      4'hD:    font = SEG_D;
      4'hE:    font = SEG_E;
      4'hF:    font = SEG_F;
      default: font = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/bcd_to_fnd_decoder.sv
// FND driver: digit-select decode plus font lookup, gated by one enable,
// with both outputs loaded on the same clock edge.
module bcd_to_fnd_decoder
  import fnd_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic                i_en,
  input  logic [SEL_W-1:0]    i_digitSelect,
  input  logic [NIBBLE_W-1:0] i_value,
  output logic [DIGIT_W-1:0]  o_digit,
  output logic [SEG_W-1:0]    o_font
);

  seg_t   rom_font;
  digit_t digit_next;
  seg_t   font_next;
  digit_t digit_reg;
  seg_t   font_reg;

  fnd_font_rom u_font_rom (
    .value (i_value),
    .font  (rom_font)
  );

  // An unknown enable takes the else path in simulation, which blanks the display.
  always_comb begin
    digit_next = DIGIT_OFF;
    font_next  = SEG_BLANK;
    if (i_en == 1'b1) begin
      digit_next = digit_decode(i_digitSelect);
      font_next  = rom_font;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      digit_reg <= DIGIT_OFF;
      font_reg  <= SEG_BLANK;
    end else begin
      digit_reg <= digit_next;
      font_reg  <= font_next;
    end
  end

  assign o_digit = digit_reg;
  assign o_font  = font_reg;

endmodule

// File: tb/tb_bcd_to_fnd_decoder.sv
// Scoreboard bench for bcd_to_fnd_decoder: inputs are driven on the falling edge,
// the expected {digit,font} is queued, and popped/compared 1 time unit after the rising edge.
module tb_bcd_to_fnd_decoder;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       i_en = 1'b1;
  logic [1:0] i_digitSelect = 2'd0;
  logic [3:0] i_value = 4'h8;
  logic [3:0] o_digit;
  logic [7:0] o_font;

  int checks = 0;
  int errors = 0;
  logic [11:0] exp_q[$];

  logic [7:0] font_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  bcd_to_fnd_decoder dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .i_en          (i_en),
    .i_digitSelect (i_digitSelect),
    .i_value       (i_value),
    .o_digit       (o_digit),
    .o_font        (o_font)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] model(input logic en, input logic [1:0] sel, input logic [3:0] val);
    logic [3:0] dig;
    if (!en) return 12'hFFF;
    dig = ~(4'b0001 << sel);
    return {dig, font_tbl[val]};
  endfunction

  task automatic drive(input logic en, input logic [1:0] sel, input logic [3:0] val);
    @(negedge clk);
    i_en = en;
    i_digitSelect = sel;
    i_value = val;
    exp_q.push_back(model(en, sel, val));
  endtask

  task automatic collect(input string tag);
    logic [11:0] e;
    @(posedge clk);
    #1;
    check({tag, "_sb"}, exp_q.size(), 1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 12'h000;
    check({tag, "_digit"}, {28'd0, o_digit}, {28'd0, e[11:8]});
    check({tag, "_font"}, {24'd0, o_font}, {24'd0, e[7:0]});
    $display("txn %s en=%0b sel=%0d val=%0h digit=%b font=%02h", tag, i_en, i_digitSelect, i_value, o_digit, o_font);
  endtask

  task automatic step(input string tag, input logic en, input logic [1:0] sel, input logic [3:0] val);
    drive(en, sel, val);
    collect(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Bring outputs to a known non-blank value so the async reset is observable.
    step("pre", 1'b1, 2'd0, 4'h8);

    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_async_digit", {28'd0, o_digit}, 32'hF);
    check("rst_async_font", {24'd0, o_font}, 32'hFF);
    @(posedge clk);
    #1;
    check("rst_hold_digit", {28'd0, o_digit}, 32'hF);
    check("rst_hold_font", {24'd0, o_font}, 32'hFF);
    drive(1'b1, 2'd0, 4'h8);
    reset_n = 1'b1;
    collect("rst_rel");

    for (int s = 0; s < 4; s++) step($sformatf("dig%0d", s), 1'b1, 2'(s), 4'h0);
    for (int v = 0; v < 16; v++) step($sformatf("font%0h", v), 1'b1, 2'd0, 4'(v));

    step("en_off", 1'b0, 2'd2, 4'hA);
    step("en_on", 1'b1, 2'd2, 4'hA);
    step("en_off2", 1'b0, 2'd3, 4'h5);
    step("en_on2", 1'b1, 2'd1, 4'h5);

    // Mid-cycle input change must not reach the outputs before the next rising edge.
    step("lat_a", 1'b1, 2'd0, 4'h3);
    i_value = 4'h9;
    i_digitSelect = 2'd1;
    exp_q.push_back(model(1'b1, 2'd1, 4'h9));
    #3;
    check("lat_hold_font", {24'd0, o_font}, 32'hB0);
    check("lat_hold_digit", {28'd0, o_digit}, 32'hE);
    collect("lat_b");

    for (int r = 0; r < 20; r++)
      step($sformatf("rnd%0d", r), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
